// File: rtl/rst_seq_pkg.sv
// Shared types and register map for the sequenced reset controller.
package rst_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [1:0] ADDR_TARGET = 2'd0;
  localparam logic [1:0] ADDR_DLY    = 2'd1;
  localparam logic [1:0] ADDR_OUT    = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int STATUS_BUSY_BIT = 8;
  localparam int STATUS_IDX_LSB  = 0;
  localparam int STATUS_IDX_W    = 5;

endpackage

// File: rtl/rst_seq_prio.sv
// Lowest-set-bit finder: one-hot, binary index and valid flag.
module rst_seq_prio
  import rst_seq_pkg::*;
#(
  parameter int NCH = 8
) (
  input  logic [NCH-1:0] vec,
  output logic [NCH-1:0] onehot,
  output logic [4:0]     idx,
  output logic           valid
);

  // Scan from the top so the lowest set bit is the last assignment.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = 5'(i);
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset control register bank with immediate assertion and staggered,
// one-channel-at-a-time release separated by a programmable gap.
//
// state | meaning
// IDLE  | no gap being timed; loads cnt from DLY when a release is pending
// WAIT  | counting the gap down; releases lowest pending channel at cnt == 0
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int              NCH           = 8,
  parameter logic [NCH-1:0]  RESET_DEFAULT = '0,
  parameter int              DLY_W         = 8,
  parameter logic [DLY_W-1:0] DLY_DEFAULT  = DLY_W'(4)
) (
  input  logic            clk,
  input  logic            e_reset_n,
  input  logic            s_reset_n,
  input  logic [NCH-1:0]  rst_in,
  input  logic            cs,
  input  logic [3:0]      we,
  input  logic [1:0]      addr,
  input  logic [31:0]     data_in,
  output logic [31:0]     data_out,
  output logic [NCH-1:0]  rst_n_out,
  output logic            seq_busy
);

  state_t           state;
  logic [DLY_W-1:0] cnt;
  logic [DLY_W-1:0] dly_q;
  logic [NCH-1:0]   target_q;
  logic [NCH-1:0]   out_q;

  logic [NCH-1:0]   pending;
  logic [NCH-1:0]   rel_onehot;
  logic [4:0]       rel_idx;
  logic             rel_valid;
  logic             release_en;

  logic [31:0]      tgt_wide;
  logic [31:0]      dly_wide;
  logic [NCH-1:0]   target_nxt;
  logic [DLY_W-1:0] dly_nxt;
  logic             unused_bits;

  assign pending = target_q & ~out_q;

  rst_seq_prio #(.NCH(NCH)) u_prio (
    .vec    (pending),
    .onehot (rel_onehot),
    .idx    (rel_idx),
    .valid  (rel_valid)
  );

  // Byte-lane merge on a full 32-bit word, then trimmed to register width.
  always_comb begin
    tgt_wide = 32'(target_q);
    dly_wide = 32'(dly_q);
    if (cs && (addr == ADDR_TARGET)) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) tgt_wide[8*b +: 8] = data_in[8*b +: 8];
      end
    end
    if (cs && (addr == ADDR_DLY)) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) dly_wide[8*b +: 8] = data_in[8*b +: 8];
      end
    end
    target_nxt = tgt_wide[NCH-1:0];
    dly_nxt    = dly_wide[DLY_W-1:0];
  end

  assign unused_bits = ^{tgt_wide, dly_wide};

  assign release_en = (state == WAIT) && (cnt == '0) && rel_valid;

  always_ff @(posedge clk or negedge e_reset_n) begin
    if (!e_reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      target_q <= '0;
      dly_q    <= DLY_DEFAULT;
      out_q    <= RESET_DEFAULT;
    end else if (!s_reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      target_q <= rst_in;
      out_q    <= RESET_DEFAULT;
    end else begin
      target_q <= target_nxt;
      dly_q    <= dly_nxt;
      // Release is masked by the post-write target so a same-cycle clear wins.
      out_q    <= (out_q & target_q) |
                  (release_en ? (rel_onehot & target_nxt) : '0);
      case (state)
        IDLE: begin
          if (pending != '0) begin
            cnt   <= dly_q;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rst_n_out = out_q;
  assign seq_busy  = (state == WAIT) || (pending != '0);

  always_comb begin
    data_out = '0;
    case (addr)
      ADDR_TARGET: data_out[NCH-1:0]   = target_q;
      ADDR_DLY:    data_out[DLY_W-1:0] = dly_q;
      ADDR_OUT:    data_out[NCH-1:0]   = out_q;
      ADDR_STATUS: begin
        data_out[STATUS_BUSY_BIT]                 = seq_busy;
        data_out[STATUS_IDX_LSB +: STATUS_IDX_W]  = rel_idx;
      end
      default: data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: cycle model compared every cycle plus literal checks.
module tb_rst_seq_ctrl;
  localparam int NCH   = 8;
  localparam int DLY_W = 8;

  logic            clk;
  logic            e_reset_n;
  logic            s_reset_n;
  logic [NCH-1:0]  rst_in;
  logic            cs;
  logic [3:0]      we;
  logic [1:0]      addr;
  logic [31:0]     data_in;
  logic [31:0]     data_out;
  logic [NCH-1:0]  rst_n_out;
  logic            seq_busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  rst_seq_ctrl #(.NCH(NCH), .DLY_W(DLY_W)) dut (
    .clk       (clk),
    .e_reset_n (e_reset_n),
    .s_reset_n (s_reset_n),
    .rst_in    (rst_in),
    .cs        (cs),
    .we        (we),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .rst_n_out (rst_n_out),
    .seq_busy  (seq_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: target/delay/output vectors plus "cycles left in the gap".
  logic [7:0] m_tgt, m_dly, m_out;
  bit         m_wait;
  int         m_left;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [7:0] p;
    int lo;
    p  = m_tgt & ~m_out;
    lo = lowest(p);
    case (a)
      2'd0:    return {24'd0, m_tgt};
      2'd1:    return {24'd0, m_dly};
      2'd2:    return {24'd0, m_out};
      default: return {23'd0, (m_wait || p != 8'd0), 3'd0, (lo < 0) ? 5'd0 : 5'(lo)};
    endcase
  endfunction

  always @(posedge clk or negedge e_reset_n) begin
    logic [7:0] p, nt, nd, rel;
    int lo;
    if (!e_reset_n) begin
      m_tgt = 8'd0; m_dly = 8'd4; m_out = 8'd0; m_wait = 0; m_left = 0;
    end else if (!s_reset_n) begin
      m_tgt = rst_in; m_out = 8'd0; m_wait = 0; m_left = 0;
    end else begin
      p   = m_tgt & ~m_out;
      nt  = m_tgt;
      nd  = m_dly;
      rel = 8'd0;
      if (cs && we[0] && addr == 2'd0) nt = data_in[7:0];
      if (cs && we[0] && addr == 2'd1) nd = data_in[7:0];
      if (!m_wait) begin
        if (p != 8'd0) begin
          m_wait = 1;
          m_left = int'(m_dly) + 1;
        end
      end else if (m_left > 1) begin
        m_left--;
      end else begin
        m_wait = 0;
        lo = lowest(p);
        if (lo >= 0) rel[lo] = 1'b1;
      end
      m_out = (m_out & m_tgt) | (rel & nt);
      m_tgt = nt;
      m_dly = nd;
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_out",  32'(rst_n_out), {24'd0, m_out});
      check("model_busy", 32'(seq_busy), 32'(m_wait || ((m_tgt & ~m_out) != 8'd0)));
      check("model_read", data_out, m_read(addr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] w, input logic [31:0] d);
    cs = 1'b1; addr = a; we = w; data_in = d;
    tick();
    cs = 1'b0; we = 4'd0;
  endtask

  task automatic rd_check(input string nm, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(nm, data_out, exp);
  endtask

  initial begin
    e_reset_n = 1'b1; s_reset_n = 1'b1; cs = 1'b0; we = 4'd0;
    addr = 2'd0; data_in = 32'd0; rst_in = '0;
    #3 e_reset_n = 1'b0;
    tick(); tick();
    check("rst_out",  32'(rst_n_out), 32'h00);
    check("rst_busy", 32'(seq_busy), 32'h0);
    rd_check("rst_dly", 2'd1, 32'd4);
    e_reset_n = 1'b1;
    chk_en = 1;

    // Straps loaded under soft reset, then released with DLY=4.
    s_reset_n = 1'b0; rst_in = 8'h05;
    tick(); tick();
    rd_check("strap_tgt", 2'd0, 32'h05);
    s_reset_n = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t == 5)  check("strap_c5",  32'(rst_n_out), 32'h00);
      if (t == 6)  check("strap_c6",  32'(rst_n_out), 32'h01);
      if (t == 11) check("strap_c11", 32'(rst_n_out), 32'h01);
      if (t == 12) check("strap_c12", 32'(rst_n_out), 32'h05);
    end

    // DLY=0, release all remaining channels two cycles apart.
    wr(2'd1, 4'b0001, 32'd0);
    wr(2'd0, 4'b0001, 32'hFF);
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t == 2)  check("all_c2",  32'(rst_n_out), 32'h07);
      if (t == 11) check("all_c11", 32'(rst_n_out), 32'h7F);
      if (t == 11) check("all_busy11", 32'(seq_busy), 32'h1);
      if (t == 12) check("all_c12", 32'(rst_n_out), 32'hFF);
      if (t == 12) check("all_busy12", 32'(seq_busy), 32'h0);
    end

    // Clearing a target bit asserts that reset one cycle later.
    wr(2'd0, 4'b0001, 32'h7F);
    check("clr_c0", 32'(rst_n_out), 32'hFF);
    tick();
    check("clr_c1", 32'(rst_n_out), 32'h7F);
    rd_check("clr_status", 2'd3, 32'h000);

    // Retarget during a long gap: bit0 abandoned, bit1 released at gap end.
    wr(2'd0, 4'b0001, 32'h00);
    tick();
    wr(2'd1, 4'b0001, 32'd10);
    wr(2'd0, 4'b0001, 32'h03);
    tick(); tick();
    rd_check("retgt_status", 2'd3, 32'h100);
    tick();
    wr(2'd0, 4'b0001, 32'h02);
    for (int t = 5; t <= 12; t++) begin
      tick();
      if (t == 11) check("retgt_c11", 32'(rst_n_out), 32'h00);
      if (t == 12) check("retgt_c12", 32'(rst_n_out), 32'h02);
    end

    // Byte enables: lane 1 misses an 8-bit target; upper bits read as 0.
    wr(2'd0, 4'b0010, 32'hFFFF_FFFF);
    rd_check("be_lane1", 2'd0, 32'h02);
    wr(2'd0, 4'b1111, 32'hFFFF_FF02);
    rd_check("be_upper", 2'd0, 32'h02);

    // Clear racing a release: the clear wins.
    wr(2'd1, 4'b0001, 32'd2);
    wr(2'd0, 4'b0001, 32'h03);
    tick(); tick(); tick();
    wr(2'd0, 4'b0001, 32'h02);
    check("race_c4", 32'(rst_n_out), 32'h02);
    tick();
    check("race_c5", 32'(rst_n_out), 32'h02);

    // Soft reset in the middle of a gap.
    wr(2'd1, 4'b0001, 32'd10);
    wr(2'd0, 4'b0001, 32'hFF);
    tick(); tick(); tick();
    s_reset_n = 1'b0; rst_in = 8'h00;
    tick();
    check("srst_out",  32'(rst_n_out), 32'h00);
    check("srst_busy", 32'(seq_busy), 32'h0);
    wr(2'd1, 4'b0001, 32'd5);
    rd_check("srst_dly", 2'd1, 32'd10);
    rd_check("srst_tgt", 2'd0, 32'h00);
    s_reset_n = 1'b1;
    tick(); tick(); tick();
    check("srst_idle", 32'(seq_busy), 32'h0);

    tick();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
